// File: rtl/fpu_pkg.sv
// Shared FPU types and constants used by the fadd issue arbiter.
package fpu_pkg;

  typedef logic [31:0] float32_t;

  localparam int FADD_LATENCY = 2;

  // Requester index to one-hot mask; callers truncate to their requester count.
  function automatic logic [7:0] onehot_id(input logic [2:0] id);
    onehot_id = 8'b1 << id;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the lowest requesting index at or after rr_ptr (mod NREQ).
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         grant,
  output logic                    grant_any,
  output logic [$clog2(NREQ)-1:0] grant_id
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0] rr_ptr;
  int             scan_idx;

  // NOTE: every output gets a default before the search, so no path can infer a latch.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    scan_idx  = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
      if (!grant_any && req[IDW'(scan_idx)]) begin
        grant_any = 1'b1;
        grant_id  = IDW'(scan_idx);
      end
    end
    grant = grant_any ? (NREQ'(1) << grant_id) : '0;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/fadd_arbiter.sv
// Shares one fixed-latency pipelined fadd among NREQ requesters with tag-routed responses.
// Optional subtract support is enabled by defining FADD_ARB_SUB_EN.
module fadd_arbiter
  import fpu_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int LATENCY = FADD_LATENCY
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_x1,
  input  logic [NREQ*32-1:0] req_x2,
`ifdef FADD_ARB_SUB_EN
  input  logic [NREQ-1:0]    req_sub,
`endif
  output float32_t           fadd_x1,
  output float32_t           fadd_x2,
  input  float32_t           fadd_y,
  output logic [NREQ-1:0]    rsp_valid,
  output float32_t           rsp_y,
  output logic               busy
);

  localparam int IDW = $clog2(NREQ);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  logic           grant_any;
  logic [IDW-1:0] grant_id;
  tag_t           tag_q [LATENCY-1];
  logic           tag_vld_any;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req_valid),
    .grant     (req_ready),
    .grant_any (grant_any),
    .grant_id  (grant_id)
  );

  always_comb begin
    fadd_x1 = '0;
    fadd_x2 = '0;
    if (grant_any) begin
      fadd_x1 = req_x1[32*grant_id +: 32];
      fadd_x2 = req_x2[32*grant_id +: 32];
`ifdef FADD_ARB_SUB_EN
      // Flipping the sign of x2 turns the add into x1 - x2.
      if (req_sub[grant_id]) fadd_x2[31] = ~fadd_x2[31];
`endif
    end
  end

  // Tag stages are control: they must clear on reset so in-flight ops never answer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LATENCY-1; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{vld: grant_any, id: grant_id};
      for (int i = 1; i < LATENCY-1; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_valid <= '0;
      rsp_y     <= '0;
    end else if (tag_q[LATENCY-2].vld) begin
      rsp_valid <= NREQ'(onehot_id(3'(tag_q[LATENCY-2].id)));
      rsp_y     <= fadd_y;
    end else begin
      rsp_valid <= '0;
    end
  end

  always_comb begin
    tag_vld_any = 1'b0;
    for (int i = 0; i < LATENCY-1; i++) tag_vld_any = tag_vld_any | tag_q[i].vld;
  end

  assign busy = grant_any | tag_vld_any | (|rsp_valid);

endmodule

// File: tb/tb_fadd_arbiter.sv
// Self-checking bench for fadd_arbiter: queue-based model plus directed literal checks.
module tb_fadd_arbiter;
  import fpu_pkg::*;

  localparam int NREQ = 4;
  localparam int LAT  = FADD_LATENCY;

  logic               clk = 1'b0;
  logic               rstn;
  logic [NREQ-1:0]    req_valid, req_ready, req_sub, rsp_valid;
  logic [NREQ*32-1:0] req_x1, req_x2;
  logic [31:0]        fadd_x1, fadd_x2, fadd_y, rsp_y;
  logic               busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fadd_arbiter #(.NREQ(NREQ), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x1    (req_x1),
    .req_x2    (req_x2),
`ifdef FADD_ARB_SUB_EN
    .req_sub   (req_sub),
`endif
    .fadd_x1   (fadd_x1),
    .fadd_x2   (fadd_x2),
    .fadd_y    (fadd_y),
    .rsp_valid (rsp_valid),
    .rsp_y     (rsp_y),
    .busy      (busy)
  );

  // Float helpers for normal numbers and zero, via double-precision reals.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    logic [10:0] e;
    if (f[30:0] == 31'h0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    d = {f[31], e, f[22:0], 29'h0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  // Behavioural fadd: LAT-1 register stages, no reset (stale data must be ignored).
  logic [31:0] fpipe [LAT-1];
  initial for (int i = 0; i < LAT-1; i++) fpipe[i] = 32'h0;
  always @(posedge clk) begin
    fpipe[0] <= fp_add(fadd_x1, fadd_x2);
    for (int i = 1; i < LAT-1; i++) fpipe[i] <= fpipe[i-1];
  end
  assign fadd_y = fpipe[LAT-2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: rotation pointer, queue of expected responses keyed by due cycle.
  typedef struct {
    int          due;
    int          id;
    logic [31:0] y;
  } exp_t;

  exp_t        q[$];
  int          m_ptr  = 0;
  int          m_cyc  = 0;
  logic [31:0] m_last = 32'h0;

  always @(negedge clk) begin
    int          g;
    logic [31:0] ex1, ex2;
    logic [NREQ-1:0] exp_rdy, exp_rsp;
    logic        sub;
    if (!rstn) begin
      q.delete();
      m_ptr  = 0;
      m_cyc  = 0;
      m_last = 32'h0;
    end else begin
      m_cyc++;
      g = -1;
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      exp_rdy = (g >= 0) ? NREQ'(1 << g) : '0;
      ex1 = 32'h0;
      ex2 = 32'h0;
      if (g >= 0) begin
        ex1 = req_x1[32*g +: 32];
        ex2 = req_x2[32*g +: 32];
`ifdef FADD_ARB_SUB_EN
        sub = req_sub[g];
`else
        sub = 1'b0;
`endif
        if (sub) ex2 = {~ex2[31], ex2[30:0]};
      end
      check("model_req_ready", req_ready, exp_rdy);
      check("model_fadd_x1", fadd_x1, ex1);
      check("model_fadd_x2", fadd_x2, ex2);
      exp_rsp = '0;
      if (q.size() > 0 && q[0].due == m_cyc) begin
        exp_rsp = NREQ'(1 << q[0].id);
        m_last  = q[0].y;
        void'(q.pop_front());
      end
      check("model_rsp_valid", rsp_valid, exp_rsp);
      check("model_rsp_y", rsp_y, m_last);
      check("model_busy", busy, (g >= 0 || q.size() > 0 || exp_rsp != 0) ? 32'h1 : 32'h0);
      if (g >= 0) begin
        q.push_back('{due: m_cyc + LAT, id: g, y: fp_add(ex1, ex2)});
        m_ptr = (g + 1) % NREQ;
      end
    end
  end

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
    req_x1[32*i +: 32] = a;
    req_x2[32*i +: 32] = b;
    req_sub[i]         = s;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn      = 1'b0;
    req_valid = '0;
    @(posedge clk); #1;
    rstn      = 1'b1;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  logic [31:0] x1tab  [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  logic [31:0] sumtab [4] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};

  initial begin
    logic [NREQ-1:0] g;
    rstn      = 1'b0;
    req_valid = '0;
    req_sub   = '0;
    req_x1    = '0;
    req_x2    = '0;

    repeat (2) @(negedge clk);
    check("reset_rsp_valid", rsp_valid, 32'h0);
    check("reset_rsp_y", rsp_y, 32'h0);
    check("reset_busy", busy, 32'h0);
    check("reset_req_ready", req_ready, 32'h0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Single op from requester 0: 1.0 + 2.0.
    set_op(0, 32'h3F800000, 32'h40000000, 1'b0);
    req_valid = 4'b0001;
    @(negedge clk);
    check("single_grant", req_ready, 32'h1);
    check("single_fadd_x1", fadd_x1, 32'h3F800000);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("single_rsp_c1", rsp_valid, 32'h0);
    check("single_busy_c1", busy, 32'h1);
    @(negedge clk);
    check("single_rsp_c2", rsp_valid, 32'h1);
    check("single_rsp_y", rsp_y, 32'h40400000);
    @(posedge clk); #1;
    idle(2);

    // All four valid, each held until granted.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, x1tab[i], 32'h3F800000, 1'b0);
    req_valid = '1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c < 4) check("rot_grant", req_ready, 32'(1 << c));
      if (c >= 2) begin
        check("rot_rsp_valid", rsp_valid, 32'(1 << (c - 2)));
        check("rot_rsp_y", rsp_y, sumtab[c-2]);
      end
      g = req_ready;
      @(posedge clk); #1;
      req_valid = req_valid & ~g;
    end
    idle(2);

    // Requesters 0 and 2 held continuously: strict alternation.
    do_reset();
    set_op(0, 32'h3F800000, 32'h3F800000, 1'b0);
    set_op(2, 32'h40800000, 32'h40000000, 1'b0);
    req_valid = 4'b0101;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("alt_grant", req_ready, (c % 2 == 0) ? 32'h1 : 32'h4);
      if (c >= 2) check("alt_rsp_y", rsp_y, (c % 2 == 0) ? 32'h40000000 : 32'h40C00000);
      @(posedge clk); #1;
    end
    idle(3);

    // Pointer wrap: move rr_ptr to 3, then requesters 1 and 3.
    do_reset();
    set_op(1, 32'h40000000, 32'h40000000, 1'b0);
    set_op(2, 32'h3F800000, 32'h3F800000, 1'b0);
    set_op(3, 32'h40400000, 32'h3F800000, 1'b0);
    req_valid = 4'b0100;
    @(negedge clk);
    check("wrap_pre", req_ready, 32'h4);
    @(posedge clk); #1;
    req_valid = 4'b1010;
    @(negedge clk);
    check("wrap_first", req_ready, 32'h8);
    @(posedge clk); #1;
    req_valid = 4'b0010;
    @(negedge clk);
    check("wrap_second", req_ready, 32'h2);
    @(posedge clk); #1;
    req_valid = 4'b1111;
    @(negedge clk);
    check("wrap_ptr2", req_ready, 32'h4);
    @(posedge clk); #1;
    idle(3);

    // Reset while two ops are in flight.
    do_reset();
    set_op(0, 32'h3F800000, 32'h3F800000, 1'b0);
    set_op(1, 32'h40000000, 32'h3F800000, 1'b0);
    set_op(2, 32'h40400000, 32'h3F800000, 1'b0);
    req_valid = 4'b0011;
    @(negedge clk);
    check("mid_grant0", req_ready, 32'h1);
    @(posedge clk); #1;
    req_valid = 4'b0010;
    @(negedge clk);
    check("mid_grant1", req_ready, 32'h2);
    #1;
    rstn      = 1'b0;
    req_valid = '0;
    @(negedge clk);
    check("mid_in_reset_rsp", rsp_valid, 32'h0);
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("mid_after_rsp", rsp_valid, 32'h0);
      check("mid_after_busy", busy, 32'h0);
    end
    @(posedge clk); #1;
    req_valid = 4'b0110;
    @(negedge clk);
    check("mid_next_grant", req_ready, 32'h2);
    @(posedge clk); #1;
    idle(3);

    // Subtract request from requester 1: 3.0 and 1.0.
    do_reset();
    set_op(1, 32'h40400000, 32'h3F800000, 1'b1);
    req_valid = 4'b0010;
    @(negedge clk);
    check("sub_grant", req_ready, 32'h2);
`ifdef FADD_ARB_SUB_EN
    check("sub_fadd_x2", fadd_x2, 32'hBF800000);
`else
    check("sub_fadd_x2", fadd_x2, 32'h3F800000);
`endif
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    check("sub_rsp_valid", rsp_valid, 32'h2);
`ifdef FADD_ARB_SUB_EN
    check("sub_rsp_y", rsp_y, 32'h40000000);
`else
    check("sub_rsp_y", rsp_y, 32'h40800000);
`endif
    @(posedge clk); #1;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
